// File: rtl/month_year.sv
// month_year: month and year stage of the calendar chain.
//
// Counts months 1..12 on each qualified day-overflow pulse and rolls the
// year (4-digit BCD, 0000..9999) when December overflows. Month and year can
// also be stepped manually through select_item with up/down. The day counter
// reads back month_bin and leap_year to choose its maximum day.
//
// Ports:
//   clk_1Hz      in   1   clock, all state changes on the rising edge
//   rst_n        in   1   synchronous active-low reset
//   en_1         in   1   count enable qualifier for carry_in
//   up           in   1   manual increment request (level)
//   down         in   1   manual decrement request (level, ignored when up)
//   select_item  in   3   adjust target selector
//   carry_in     in   1   one-cycle day-overflow pulse
//   month_bin    out  4   month, binary 1..12
//   year_bcd     out  16  year, BCD, [15:12] thousands .. [3:0] units
//   leap_year    out  1   Gregorian leap flag for year_bcd (combinational)
//   carry_out    out  1   one-cycle pulse when counting wraps 9999 -> 0000
module month_year #(
  parameter logic [2:0]  SELECT_MONTH = 3'b100,
  parameter logic [2:0]  SELECT_YEAR  = 3'b101,
  parameter logic [15:0] RESET_YEAR   = 16'h2000
) (
  input  logic        clk_1Hz,
  input  logic        rst_n,
  input  logic        en_1,
  input  logic        up,
  input  logic        down,
  input  logic [2:0]  select_item,
  input  logic        carry_in,
  output logic [3:0]  month_bin,
  output logic [15:0] year_bcd,
  output logic        leap_year,
  output logic        carry_out
);

  typedef enum logic [1:0] {
    OpIdle,
    OpMonthAdj,
    OpYearAdj,
    OpCount
  } op_e;

  logic [3:0]  month_q, month_d;
  logic [15:0] year_q, year_d;
  logic        carry_q, carry_d;
  op_e         op;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Ripple BCD increment. Any digit >= 9 rolls to 0 and carries, so a corrupt
  // digit is pulled back into the valid range.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple BCD decrement. A zero digit borrows and becomes 9; a corrupt digit
  // (>9) is clamped to 9 without borrowing.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          b           = 1'b1;
        end else if (v[4*i +: 4] > 4'd9) begin
          r[4*i +: 4] = 4'd9;
          b           = 1'b0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Illegal months (0, 13..15) restart at January.
  function automatic logic [3:0] month_inc(input logic [3:0] m);
    if (m == 4'd0 || m >= 4'd12) begin
      return 4'd1;
    end
    return m + 4'd1;
  endfunction

  // Illegal months (0, 13..15) restart at December.
  function automatic logic [3:0] month_dec(input logic [3:0] m);
    if (m <= 4'd1 || m > 4'd12) begin
      return 4'd12;
    end
    return m - 4'd1;
  endfunction

  // Divisibility by 4 of the two-digit number {t,u}: 10 = 2 mod 4, so an even
  // tens digit needs u in {0,4,8} and an odd one needs u in {2,6}.
  function automatic logic div4(input logic [3:0] t, input logic [3:0] u);
    if (!t[0]) begin
      return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
    end
    return (u == 4'd2) || (u == 4'd6);
  endfunction

  // ---------------------------------------------------------------------------
  // Operation decode: adjust modes outrank counting, and a carry_in seen while
  // adjusting is simply dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    op = OpIdle;
    if (select_item == SELECT_MONTH) begin
      op = OpMonthAdj;
    end else if (select_item == SELECT_YEAR) begin
      op = OpYearAdj;
    end else if (en_1 && carry_in) begin
      op = OpCount;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    month_d = month_q;
    year_d  = year_q;
    carry_d = 1'b0;
    unique case (op)
      OpMonthAdj: begin
        if (up) begin
          month_d = month_inc(month_q);
        end else if (down) begin
          month_d = month_dec(month_q);
        end
      end
      OpYearAdj: begin
        if (up) begin
          year_d = bcd_inc(year_q);
        end else if (down) begin
          year_d = bcd_dec(year_q);
        end
      end
      OpCount: begin
        month_d = month_inc(month_q);
        if (month_q == 4'd12) begin
          year_d  = bcd_inc(year_q);
          carry_d = (year_q == 16'h9999);
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      month_q <= 4'd1;
      year_q  <= RESET_YEAR;
      carry_q <= 1'b0;
    end else begin
      month_q <= month_d;
      year_q  <= year_d;
      carry_q <= carry_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign month_bin = month_q;
  assign year_bcd  = year_q;
  assign carry_out = carry_q;

  // Century years (tens and units both zero) are leap only when the century
  // number itself is divisible by 4; year 0000 lands here and reads as leap.
  always_comb begin
    if (year_q[7:4] == 4'd0 && year_q[3:0] == 4'd0) begin
      leap_year = div4(year_q[15:12], year_q[11:8]);
    end else begin
      leap_year = div4(year_q[7:4], year_q[3:0]);
    end
  end

endmodule

// File: tb/tb_month_year.sv
module tb_month_year;

  localparam logic [2:0] SM = 3'b100;
  localparam logic [2:0] SY = 3'b101;
  localparam logic [2:0] SN = 3'b000;

  logic        clk_1Hz = 1'b0;
  logic        rst_n, en_1, up, down, carry_in;
  logic [2:0]  select_item;
  logic [3:0]  month_bin;
  logic [15:0] year_bcd;
  logic        leap_year, carry_out;

  int n_cmp = 0;
  int n_err = 0;
  int cur_year;

  month_year #(
    .SELECT_MONTH (SM),
    .SELECT_YEAR  (SY),
    .RESET_YEAR   (16'h2000)
  ) dut (
    .clk_1Hz     (clk_1Hz),
    .rst_n       (rst_n),
    .en_1        (en_1),
    .up          (up),
    .down        (down),
    .select_item (select_item),
    .carry_in    (carry_in),
    .month_bin   (month_bin),
    .year_bcd    (year_bcd),
    .leap_year   (leap_year),
    .carry_out   (carry_out)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        up;
    logic        dn;
    logic [2:0]  sel;
    logic        cin;
    logic [3:0]  m;
    logic [15:0] y;
    logic        co;
    logic        lp;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic u, logic d, logic [2:0] s, logic c,
                              logic [3:0] m, logic [15:0] y, logic co, logic lp);
    vec_t v;
    v.rst_n = r; v.en = e; v.up = u; v.dn = d; v.sel = s; v.cin = c;
    v.m = m; v.y = y; v.co = co; v.lp = lp;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(int y);
    logic [15:0] r;
    r[15:12] = 4'((y / 1000) % 10);
    r[11:8]  = 4'((y / 100) % 10);
    r[7:4]   = 4'((y / 10) % 10);
    r[3:0]   = 4'(y % 10);
    return r;
  endfunction

  task automatic step(logic r, logic e, logic u, logic d, logic [2:0] s, logic c);
    rst_n = r; en_1 = e; up = u; down = d; select_item = s; carry_in = c;
    @(posedge clk_1Hz);
    #1;
    if (!r) cur_year = 2000;
  endtask

  task automatic check(string name, logic [3:0] m, logic [15:0] y, logic co, logic lp);
    n_cmp++;
    if (month_bin !== m) begin
      n_err++;
      $display("FAIL %s month: got %0d want %0d", name, month_bin, m);
    end
    n_cmp++;
    if (year_bcd !== y) begin
      n_err++;
      $display("FAIL %s year: got %h want %h", name, year_bcd, y);
    end
    n_cmp++;
    if (carry_out !== co) begin
      n_err++;
      $display("FAIL %s carry_out: got %b want %b", name, carry_out, co);
    end
    n_cmp++;
    if (leap_year !== lp) begin
      n_err++;
      $display("FAIL %s leap: got %b want %b", name, leap_year, lp);
    end
  endtask

  // One year-adjust step; the bench tracks the decimal year independently.
  task automatic year_step(bit inc);
    step(1'b1, 1'b0, inc, !inc, SY, 1'b0);
    if (inc) cur_year = (cur_year == 9999) ? 0 : cur_year + 1;
    else     cur_year = (cur_year == 0) ? 9999 : cur_year - 1;
  endtask

  task automatic goto_year(int target);
    int guard = 0;
    while (cur_year != target && guard < 10000) begin
      year_step(target > cur_year);
      guard++;
    end
  endtask

  vec_t vecs[15];
  int   leap_years[7] = '{1900, 1996, 2000, 2023, 2024, 2100, 2400};
  bit   leap_exp[7]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; en_1 = 1'b0; up = 1'b0; down = 1'b0; select_item = SN; carry_in = 1'b0;
    cur_year = 2000;

    //            rst  en   up   dn   sel cin   month  year      co   leap
    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, SN, 1'b1, 4'd1,  16'h2000, 1'b0, 1'b1);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, SN, 1'b0, 4'd1,  16'h2000, 1'b0, 1'b1);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b1, SM, 1'b0, 4'd12, 16'h2000, 1'b0, 1'b1);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, SY, 1'b0, 4'd12, 16'h1999, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, SN, 1'b1, 4'd1,  16'h2000, 1'b0, 1'b1);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, SN, 1'b0, 4'd1,  16'h2000, 1'b0, 1'b1);
    vecs[6]  = mk(1'b1, 1'b0, 1'b1, 1'b0, SM, 1'b0, 4'd2,  16'h2000, 1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 1'b1, 1'b1, SM, 1'b0, 4'd3,  16'h2000, 1'b0, 1'b1);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, SY, 1'b1, 4'd3,  16'h2000, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, SM, 1'b1, 4'd3,  16'h2000, 1'b0, 1'b1);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, SN, 1'b1, 4'd3,  16'h2000, 1'b0, 1'b1);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, SN, 1'b1, 4'd4,  16'h2000, 1'b0, 1'b1);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, SY, 1'b0, 4'd4,  16'h1999, 1'b0, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 1'b1, SY, 1'b0, 4'd4,  16'h2000, 1'b0, 1'b1);
    vecs[14] = mk(1'b0, 1'b1, 1'b1, 1'b0, SM, 1'b1, 4'd1,  16'h2000, 1'b0, 1'b1);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].up, vecs[i].dn, vecs[i].sel, vecs[i].cin);
      check($sformatf("vec%0d", i), vecs[i].m, vecs[i].y, vecs[i].co, vecs[i].lp);
    end

    // Year adjust rollovers and the 9999 -> 0000 count wrap.
    step(1'b0, 1'b0, 1'b0, 1'b0, SN, 1'b0);
    goto_year(999);
    check("year_0999", 4'd1, 16'h0999, 1'b0, 1'b0);
    year_step(1'b1);
    check("year_up_1000", 4'd1, 16'h1000, 1'b0, 1'b0);
    goto_year(0);
    check("year_0000", 4'd1, 16'h0000, 1'b0, 1'b1);
    year_step(1'b0);
    check("year_dn_9999", 4'd1, 16'h9999, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, SM, 1'b0);
    check("month_dn_12", 4'd12, 16'h9999, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, SN, 1'b1);
    check("wrap_9999", 4'd1, 16'h0000, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, SN, 1'b0);
    check("wrap_pulse_end", 4'd1, 16'h0000, 1'b0, 1'b1);

    // up && down collision at month 5.
    step(1'b0, 1'b0, 1'b0, 1'b0, SN, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, SM, 1'b0);
    check("month_5", 4'd5, 16'h2000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, SM, 1'b0);
    check("month_updn_6", 4'd6, 16'h2000, 1'b0, 1'b1);

    // Leap rule across century and ordinary years.
    step(1'b0, 1'b0, 1'b0, 1'b0, SN, 1'b0);
    for (int i = 0; i < 7; i++) begin
      goto_year(leap_years[i]);
      check($sformatf("leap_%0d", leap_years[i]), 4'd1, to_bcd(leap_years[i]), 1'b0,
            leap_exp[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
